// File: rtl/ddr_load_arbiter_pkg.sv
// Shared types and helpers for the DDR load-channel arbiter.
package ddr_arbiter_pkg;

   typedef enum logic {IDLE, WAIT} arb_state_e;

   localparam int unsigned ARB_FIXED       = 0;
   localparam int unsigned ARB_ROUND_ROBIN = 1;

   // Width of a requester index; never narrower than one bit.
   function automatic int unsigned clog2_req(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/ddr_load_arbiter_rr_priority_picker.sv
// Combinational rotate-search: first set mask bit at or after start_i, wrapping.
module rr_priority_picker #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [N-1:0]     mask_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [IDX_W-1:0] winner_o,
   output logic             found_o
);

   logic [2*N-1:0] rot;
   int unsigned    pos;

   always_comb begin
      rot      = {mask_i, mask_i} >> start_i;
      winner_o = '0;
      found_o  = 1'b0;
      pos      = 0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!found_o && rot[k]) begin
            found_o = 1'b1;
            pos     = 32'(start_i) + k;
            if (pos >= N) pos = pos - N;
            winner_o = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/ddr_load_arbiter.sv
// N-way arbiter sharing one DDR load port among cache refill requesters,
// with pending buffers, aging or round-robin, invalidate and a response watchdog.
module ddr_load_arbiter
   import ddr_arbiter_pkg::*;
#(
   parameter int unsigned       N_REQ        = 2,
   parameter int unsigned       ADDR_W       = 32,
   parameter int unsigned       DATA_W       = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDRESS = '0,
   parameter int unsigned       RR_MODE      = 0,
   parameter int unsigned       AGE_LIMIT    = 16,
   parameter int unsigned       TIMEOUT      = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [N_REQ-1:0]         req_request_i,
   input  logic [N_REQ*ADDR_W-1:0]  req_address_i,
   input  logic [N_REQ-1:0]         req_invalidate_i,
   output logic [N_REQ-1:0]         req_grant_o,
   output logic [N_REQ-1:0]         req_valid_o,
   output logic [DATA_W-1:0]        req_data_o,
   output logic [N_REQ-1:0]         req_stall_o,
   output logic                     ddr_request_o,
   output logic [ADDR_W-1:0]        ddr_address_o,
   output logic                     ddr_invalidate_o,
   input  logic                     ddr_valid_i,
   input  logic [DATA_W-1:0]        ddr_data_i,
   input  logic                     ldr_ready_i,
   output logic                     timeout_o
);

   localparam int unsigned IDX_W = clog2_req(N_REQ);
   localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

   arb_state_e        state_q;
   logic [N_REQ-1:0]  pending_q;
   logic [ADDR_W-1:0] addr_q [N_REQ];
   logic [AGE_W-1:0]  age_q  [N_REQ];
   logic [IDX_W-1:0]  gnt_q;
   logic [IDX_W-1:0]  rr_ptr_q;
   logic              seen_q;
   logic              cancel_q;
   logic [WD_W-1:0]   wd_q;

   logic [ADDR_W-1:0] req_addr [N_REQ];
   logic [N_REQ-1:0]  cand;
   logic [N_REQ-1:0]  aged;
   logic [N_REQ-1:0]  pick_mask;
   logic [IDX_W-1:0]  pick_start;
   logic [IDX_W-1:0]  win;
   logic              found;
   logic              do_grant;
   logic [N_REQ-1:0]  gnt_onehot;
   logic [ADDR_W-1:0] win_addr;
   logic              wait_end;
   logic              wd_fire;
   logic              inval_gnt;

   // Same-cycle requests bypass the pending buffer; an invalidate always wins.
   always_comb begin
      cand       = (pending_q | req_request_i) & ~req_invalidate_i;
      aged       = '0;
      win_addr   = '0;
      gnt_onehot = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         req_addr[i] = req_address_i[i*ADDR_W +: ADDR_W];
         aged[i]     = cand[i] && (age_q[i] == AGE_W'(AGE_LIMIT));
      end
      if (RR_MODE == ARB_ROUND_ROBIN) begin
         pick_mask  = cand;
         pick_start = rr_ptr_q;
      end else begin
         pick_mask  = (|aged) ? aged : cand;
         pick_start = '0;
      end
      do_grant = (state_q == IDLE) && found && ldr_ready_i;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win == IDX_W'(i)) begin
            win_addr      = req_request_i[i] ? req_addr[i] : addr_q[i];
            gnt_onehot[i] = do_grant;
         end
      end
   end

   rr_priority_picker #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .mask_i   (pick_mask),
      .start_i  (pick_start),
      .winner_o (win),
      .found_o  (found)
   );

   // Completion (falling edge after a beat) takes precedence over the watchdog.
   always_comb begin
      wait_end  = (state_q == WAIT) && seen_q && !ddr_valid_i;
      wd_fire   = (state_q == WAIT) && !ddr_valid_i && !wait_end
                  && (wd_q == WD_W'(TIMEOUT - 1));
      inval_gnt = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         req_valid_o[i] = (state_q == WAIT) && (gnt_q == IDX_W'(i)) && ddr_valid_i && !cancel_q;
         req_stall_o[i] = (state_q == WAIT) && (gnt_q != IDX_W'(i));
         if ((state_q == WAIT) && (gnt_q == IDX_W'(i)) && req_invalidate_i[i]) inval_gnt = 1'b1;
      end
      req_data_o = (state_q == WAIT) ? ddr_data_i : '0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q          <= IDLE;
         pending_q        <= '0;
         gnt_q            <= '0;
         rr_ptr_q         <= '0;
         seen_q           <= 1'b0;
         cancel_q         <= 1'b0;
         wd_q             <= '0;
         req_grant_o      <= '0;
         ddr_request_o    <= 1'b0;
         ddr_address_o    <= '0;
         ddr_invalidate_o <= 1'b0;
         timeout_o        <= 1'b0;
         for (int unsigned i = 0; i < N_REQ; i++) begin
            addr_q[i] <= '0;
            age_q[i]  <= '0;
         end
      end else begin
         req_grant_o      <= '0;
         ddr_request_o    <= 1'b0;
         ddr_invalidate_o <= 1'b0;
         timeout_o        <= 1'b0;

         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_request_i[i]) addr_q[i] <= req_addr[i];
            if (req_invalidate_i[i] || gnt_onehot[i]) begin
               pending_q[i] <= 1'b0;
               age_q[i]     <= '0;
            end else begin
               if (req_request_i[i]) pending_q[i] <= 1'b1;
               if (pending_q[i] && (age_q[i] != AGE_W'(AGE_LIMIT))) age_q[i] <= age_q[i] + 1'b1;
            end
         end

         case (state_q)
            IDLE: begin
               if (do_grant) begin
                  state_q       <= WAIT;
                  ddr_request_o <= 1'b1;
                  ddr_address_o <= win_addr - BASE_ADDRESS;
                  req_grant_o   <= gnt_onehot;
                  gnt_q         <= win;
                  rr_ptr_q      <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                  seen_q        <= 1'b0;
                  cancel_q      <= 1'b0;
                  wd_q          <= '0;
               end
            end
            WAIT: begin
               if (ddr_valid_i) begin
                  seen_q <= 1'b1;
                  wd_q   <= '0;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
               if (inval_gnt && !cancel_q) begin
                  cancel_q         <= 1'b1;
                  ddr_invalidate_o <= 1'b1;
               end
               if (wait_end) begin
                  state_q <= IDLE;
               end else if (wd_fire) begin
                  state_q   <= IDLE;
                  timeout_o <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_load_arbiter.sv
// Directed bench: three arbiter configurations (fixed/N=2, aging/N=3, round-robin/N=4).
module tb_ddr_load_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Instance A: N=2, base 0x8000_0000, fixed priority, TIMEOUT=8
   logic [1:0]  a_req = '0, a_inv = '0, a_grant, a_valid, a_stall;
   logic [63:0] a_addr = '0;
   logic [31:0] a_data, a_ddr_addr, a_ddr_data = '0;
   logic        a_ddr_req, a_ddr_inv, a_ddr_valid = 1'b0, a_ready = 1'b1, a_timeout;

   // Instance B: N=3, AGE_LIMIT=4
   logic [2:0]  b_req = '0, b_grant, b_valid, b_stall;
   logic [95:0] b_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
   logic [31:0] b_data, b_ddr_addr;
   logic        b_ddr_req, b_ddr_inv, b_ddr_valid = 1'b0, b_req_d = 1'b0, b_timeout;

   // Instance C: N=4, round-robin
   logic [3:0]   c_req = '0, c_grant, c_valid, c_stall;
   logic [127:0] c_addr = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
   logic [31:0]  c_data, c_ddr_addr;
   logic         c_ddr_req, c_ddr_inv, c_ddr_valid = 1'b0, c_req_d = 1'b0, c_timeout;

   ddr_load_arbiter #(
      .N_REQ(2), .ADDR_W(32), .DATA_W(32), .BASE_ADDRESS(32'h8000_0000),
      .RR_MODE(0), .AGE_LIMIT(16), .TIMEOUT(8)
   ) u_a (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_request_i(a_req), .req_address_i(a_addr), .req_invalidate_i(a_inv),
      .req_grant_o(a_grant), .req_valid_o(a_valid), .req_data_o(a_data), .req_stall_o(a_stall),
      .ddr_request_o(a_ddr_req), .ddr_address_o(a_ddr_addr), .ddr_invalidate_o(a_ddr_inv),
      .ddr_valid_i(a_ddr_valid), .ddr_data_i(a_ddr_data), .ldr_ready_i(a_ready),
      .timeout_o(a_timeout)
   );

   ddr_load_arbiter #(
      .N_REQ(3), .ADDR_W(32), .DATA_W(32), .BASE_ADDRESS(32'h0),
      .RR_MODE(0), .AGE_LIMIT(4), .TIMEOUT(1024)
   ) u_b (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_request_i(b_req), .req_address_i(b_addr), .req_invalidate_i(3'b000),
      .req_grant_o(b_grant), .req_valid_o(b_valid), .req_data_o(b_data), .req_stall_o(b_stall),
      .ddr_request_o(b_ddr_req), .ddr_address_o(b_ddr_addr), .ddr_invalidate_o(b_ddr_inv),
      .ddr_valid_i(b_ddr_valid), .ddr_data_i(32'h1111_2222), .ldr_ready_i(1'b1),
      .timeout_o(b_timeout)
   );

   ddr_load_arbiter #(
      .N_REQ(4), .ADDR_W(32), .DATA_W(32), .BASE_ADDRESS(32'h0),
      .RR_MODE(1), .AGE_LIMIT(16), .TIMEOUT(1024)
   ) u_c (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_request_i(c_req), .req_address_i(c_addr), .req_invalidate_i(4'b0000),
      .req_grant_o(c_grant), .req_valid_o(c_valid), .req_data_o(c_data), .req_stall_o(c_stall),
      .ddr_request_o(c_ddr_req), .ddr_address_o(c_ddr_addr), .ddr_invalidate_o(c_ddr_inv),
      .ddr_valid_i(c_ddr_valid), .ddr_data_i(32'h3333_4444), .ldr_ready_i(1'b1),
      .timeout_o(c_timeout)
   );

   // DDR model for A: after a request seen in cycle W, a_beats_cfg beats in W+1.. with data DA7A_0000+k
   int   a_beats_cfg = 0;
   int   a_left = 0;
   int   a_idx = 0;
   logic a_spur = 1'b0;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         a_left = 0;
         a_ddr_valid = 1'b0;
      end else if (a_left > 0) begin
         a_ddr_valid = 1'b1;
         a_ddr_data  = 32'hDA7A_0000 + 32'(a_idx);
         a_idx++;
         a_left--;
      end else begin
         a_ddr_valid = a_spur;
         a_ddr_data  = a_spur ? 32'h5EED_0000 : 32'h0;
      end
      if (rst_n && a_ddr_req) begin
         a_left = a_beats_cfg;
         a_idx  = 0;
      end
   end

   // DDR models for B and C: a single beat one cycle after the request
   initial forever begin
      @(negedge clk);
      b_ddr_valid = b_req_d;
      b_req_d     = b_ddr_req;
      c_ddr_valid = c_req_d;
      c_req_d     = c_ddr_req;
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      total++; if ({a_grant, a_valid, a_stall} !== 6'b0) begin bad++; $display("FAIL reset_a_req_side got=%b want=0", {a_grant, a_valid, a_stall}); end
      total++; if ({a_ddr_req, a_ddr_inv, a_timeout} !== 3'b0) begin bad++; $display("FAIL reset_a_ddr_side got=%b want=0", {a_ddr_req, a_ddr_inv, a_timeout}); end
      total++; if (a_ddr_addr !== 32'h0) begin bad++; $display("FAIL reset_a_addr got=%h want=0", a_ddr_addr); end
      total++; if (a_data !== 32'h0) begin bad++; $display("FAIL reset_a_data got=%h want=0", a_data); end
      total++; if ({b_grant, c_grant} !== 7'b0) begin bad++; $display("FAIL reset_bc_grant got=%b want=0", {b_grant, c_grant}); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      int nv0, nv1;
      @(negedge clk);
      a_beats_cfg = 4; a_req = 2'b10; a_addr[63:32] = 32'h8000_0040;
      @(negedge clk);
      a_req = 2'b00; #1;
      total++; if (a_ddr_req !== 1'b1) begin bad++; $display("FAIL single_ddr_req got=%b want=1", a_ddr_req); end
      total++; if (a_ddr_addr !== 32'h0000_0040) begin bad++; $display("FAIL single_addr got=%h want=00000040", a_ddr_addr); end
      total++; if (a_grant !== 2'b10) begin bad++; $display("FAIL single_grant got=%b want=10", a_grant); end
      total++; if (a_stall !== 2'b01) begin bad++; $display("FAIL single_stall got=%b want=01", a_stall); end
      nv0 = 0; nv1 = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk); #1;
         if (a_valid[1]) begin
            total++; if (a_data !== 32'hDA7A_0000 + 32'(nv1)) begin bad++; $display("FAIL single_beat_data got=%h want=%h", a_data, 32'hDA7A_0000 + 32'(nv1)); end
            nv1++;
         end
         if (a_valid[0]) nv0++;
         if (k == 5) begin
            total++; if (a_stall !== 2'b01) begin bad++; $display("FAIL single_stall_fall got=%b want=01", a_stall); end
         end
         if (k == 6) begin
            total++; if (a_stall !== 2'b00) begin bad++; $display("FAIL single_idle got=%b want=00", a_stall); end
         end
      end
      total++; if (nv1 !== 4) begin bad++; $display("FAIL single_beats1 got=%0d want=4", nv1); end
      total++; if (nv0 !== 0) begin bad++; $display("FAIL single_beats0 got=%0d want=0", nv0); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      a_beats_cfg = 2; a_req = 2'b11; a_addr = {32'h8000_2000, 32'h8000_1000};
      @(negedge clk);
      a_req = 2'b00; #1;
      total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL b2b_grant0 got=%b want=01", a_grant); end
      total++; if (a_ddr_addr !== 32'h0000_1000) begin bad++; $display("FAIL b2b_addr0 got=%h want=00001000", a_ddr_addr); end
      total++; if (a_stall !== 2'b10) begin bad++; $display("FAIL b2b_stall_w got=%b want=10", a_stall); end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk); #1;
         if (k <= 3) begin
            total++; if (a_stall[1] !== 1'b1) begin bad++; $display("FAIL b2b_stall1 cyc=%0d got=%b want=1", k, a_stall[1]); end
         end
         if (k == 4) begin
            total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL b2b_early_grant got=%b want=00", a_grant); end
         end
         if (k == 5) begin
            total++; if (a_grant !== 2'b10) begin bad++; $display("FAIL b2b_grant1 got=%b want=10", a_grant); end
            total++; if (a_ddr_addr !== 32'h0000_2000) begin bad++; $display("FAIL b2b_addr1 got=%h want=00002000", a_ddr_addr); end
         end
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_idle_valid();
      @(negedge clk);
      a_spur = 1'b1;
      @(negedge clk); #1;
      total++; if ({a_valid, a_stall} !== 4'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", {a_valid, a_stall}); end
      a_spur = 1'b0;
      @(negedge clk); #1;
      total++; if ({a_grant, a_ddr_req} !== 3'b0) begin bad++; $display("FAIL idle_no_grant got=%b want=0", {a_grant, a_ddr_req}); end
   endtask

   task automatic test_ready_hold();
      @(negedge clk);
      a_ready = 1'b0; a_beats_cfg = 1; a_req = 2'b01; a_addr[31:0] = 32'h8000_0300;
      @(negedge clk);
      a_req = 2'b00; #1;
      total++; if ({a_grant, a_ddr_req} !== 3'b0) begin bad++; $display("FAIL hold_grant1 got=%b want=0", {a_grant, a_ddr_req}); end
      @(negedge clk);
      a_req = 2'b01; a_addr[31:0] = 32'h8000_0400;
      @(negedge clk);
      a_req = 2'b00; #1;
      total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL hold_grant2 got=%b want=00", a_grant); end
      @(negedge clk);
      a_ready = 1'b1; #1;
      total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL hold_grant3 got=%b want=00", a_grant); end
      @(negedge clk); #1;
      total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL hold_release got=%b want=01", a_grant); end
      total++; if (a_ddr_addr !== 32'h0000_0400) begin bad++; $display("FAIL hold_overwrite_addr got=%h want=00000400", a_ddr_addr); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_req_invalidate_same();
      logic seen;
      @(negedge clk);
      a_req = 2'b10; a_inv = 2'b10; a_addr[63:32] = 32'h8000_0500;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         a_req = 2'b00; a_inv = 2'b00; #1;
         if (a_grant !== 2'b00 || a_ddr_req !== 1'b0) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL req_inv_same got=grant want=no_grant"); end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      a_beats_cfg = 1; a_req = 2'b01; a_addr[31:0] = 32'h0000_0010;
      @(negedge clk);
      a_req = 2'b00; #1;
      total++; if (a_ddr_addr !== 32'h8000_0010) begin bad++; $display("FAIL wrap_addr got=%h want=80000010", a_ddr_addr); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_invalidate();
      int ninv, nv0;
      @(negedge clk);
      a_beats_cfg = 3; a_req = 2'b01; a_addr[31:0] = 32'h8000_0100;
      @(negedge clk);
      a_req = 2'b00; a_inv = 2'b01; #1;
      total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL inv_grant got=%b want=01", a_grant); end
      ninv = 0; nv0 = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         a_inv = 2'b00; #1;
         if (k == 1) begin
            total++; if (a_ddr_inv !== 1'b1) begin bad++; $display("FAIL inv_pulse got=%b want=1", a_ddr_inv); end
         end
         if (a_ddr_inv === 1'b1) ninv++;
         if (a_valid !== 2'b00) nv0++;
      end
      total++; if (ninv !== 1) begin bad++; $display("FAIL inv_pulse_count got=%0d want=1", ninv); end
      total++; if (nv0 !== 0) begin bad++; $display("FAIL inv_routed_beats got=%0d want=0", nv0); end
      @(negedge clk);
      a_beats_cfg = 1; a_req = 2'b10; a_addr[63:32] = 32'h8000_0600;
      @(negedge clk);
      a_req = 2'b00; #1;
      total++; if (a_grant !== 2'b10) begin bad++; $display("FAIL inv_next_grant got=%b want=10", a_grant); end
      total++; if (a_ddr_addr !== 32'h0000_0600) begin bad++; $display("FAIL inv_next_addr got=%h want=00000600", a_ddr_addr); end
      @(negedge clk); #1;
      total++; if (a_valid !== 2'b10) begin bad++; $display("FAIL inv_next_valid got=%b want=10", a_valid); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_watchdog();
      @(negedge clk);
      a_beats_cfg = 0; a_req = 2'b01; a_addr[31:0] = 32'h8000_0700;
      @(negedge clk);
      a_req = 2'b00; #1;
      total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL wd_grant got=%b want=01", a_grant); end
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk); #1;
         total++; if (a_timeout !== (k == 8)) begin bad++; $display("FAIL wd_timeout cyc=%0d got=%b want=%b", k, a_timeout, (k == 8)); end
         total++; if (a_stall !== ((k < 8) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL wd_stall cyc=%0d got=%b", k, a_stall); end
         total++; if (a_grant !== 2'b00) begin bad++; $display("FAIL wd_regrant cyc=%0d got=%b want=00", k, a_grant); end
      end
   endtask

   task automatic test_aging();
      int got[3];
      int gcyc[3];
      int ng;
      ng = 0;
      for (int cyc = 0; cyc < 30 && ng < 3; cyc++) begin
         @(negedge clk);
         b_req = (cyc == 0) ? 3'b101 : 3'b001; #1;
         if (b_grant !== 3'b000) begin
            for (int j = 0; j < 3; j++) if (b_grant[j]) got[ng] = j;
            gcyc[ng] = cyc;
            ng++;
         end
      end
      @(negedge clk);
      b_req = 3'b000;
      total++; if (ng !== 3) begin bad++; $display("FAIL aging_grant_count got=%0d want=3", ng); end
      else begin
         total++; if (got[0] !== 0 || got[1] !== 0) begin bad++; $display("FAIL aging_first got=%0d,%0d want=0,0", got[0], got[1]); end
         total++; if (got[2] !== 2) begin bad++; $display("FAIL aging_promoted got=%0d want=2", got[2]); end
         total++; if (gcyc[2] !== 9) begin bad++; $display("FAIL aging_cycle got=%0d want=9", gcyc[2]); end
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_round_robin();
      int got[5];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int ng;
      ng = 0;
      for (int cyc = 0; cyc < 40 && ng < 5; cyc++) begin
         @(negedge clk);
         c_req = 4'b1111; #1;
         if (c_grant !== 4'b0000) begin
            for (int j = 0; j < 4; j++) if (c_grant[j]) got[ng] = j;
            ng++;
         end
      end
      @(negedge clk);
      c_req = 4'b0000;
      total++; if (ng !== 5) begin bad++; $display("FAIL rr_grant_count got=%0d want=5", ng); end
      for (int i = 0; i < ng; i++) begin
         total++; if (got[i] !== exp_order[i]) begin bad++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, got[i], exp_order[i]); end
      end
   endtask

   task automatic test_reset_mid_wait();
      logic seen;
      @(negedge clk);
      a_beats_cfg = 0; a_req = 2'b01; a_addr[31:0] = 32'h8000_0800;
      @(negedge clk);
      a_req = 2'b10; a_addr[63:32] = 32'h8000_0900; #1;
      total++; if (a_grant !== 2'b01) begin bad++; $display("FAIL rst_mid_grant got=%b want=01", a_grant); end
      @(negedge clk);
      a_req = 2'b00; #1;
      total++; if (a_stall !== 2'b10) begin bad++; $display("FAIL rst_mid_wait got=%b want=10", a_stall); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({a_grant, a_valid, a_stall, a_ddr_req, a_ddr_inv, a_timeout} !== 9'b0) begin bad++; $display("FAIL rst_mid_outputs got=%b want=0", {a_grant, a_valid, a_stall, a_ddr_req, a_ddr_inv, a_timeout}); end
      total++; if (a_ddr_addr !== 32'h0) begin bad++; $display("FAIL rst_mid_addr got=%h want=0", a_ddr_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         if (a_grant !== 2'b00) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_pending got=grant want=no_grant"); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_idle_valid();
      test_ready_hold();
      test_req_invalidate_same();
      test_wrap();
      test_invalidate();
      test_watchdog();
      test_aging();
      test_round_robin();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_time_limit got=running want=finished");
      $fatal(1);
   end

endmodule
